// File: rtl/dmem_bus_pkg.sv
// Shared types and defaults for the data-memory APB bridge and its address decoder.
package dmem_bus_pkg;

  // Bridge transfer phases; DONE is the single cycle in which the core commits.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } bus_state_e;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1000_0000;
  localparam logic [31:0] SLAVE_WINDOW      = 32'h0000_1000;

  // Upper bound on slave count; the request struct carries a select vector this wide.
  localparam int MAX_SLAVES = 16;

  // Request captured when leaving IDLE and held stable for the whole APB transfer.
  typedef struct packed {
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic [3:0]            strb;
    logic                  write;
    logic [MAX_SLAVES-1:0] sel;
  } bus_req_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational address decoder: one 4 KB window per slave starting at BASE_ADDR.
// Also used by the instruction-fetch path, so it carries no state.
module apb_addr_decode
  import dmem_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          NUM_SLAVES = 4
) (
  input  logic [31:0]           addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  hit
);

  localparam int PAGE_LSB = $clog2(SLAVE_WINDOW);
  localparam int PAGE_W   = 32 - PAGE_LSB;
  localparam logic [PAGE_W-1:0] BASE_PAGE = BASE_ADDR[31:PAGE_LSB];

  logic [PAGE_W-1:0]   page;
  logic [PAGE_LSB-1:0] unused_offset;

  assign page          = addr[31:PAGE_LSB];
  assign unused_offset = addr[PAGE_LSB-1:0];

  // Compare the page number against each slave's page; at most one can match.
  always_comb begin
    sel = '0;
    for (int n = 0; n < NUM_SLAVES; n++) begin
      if (page == BASE_PAGE + PAGE_W'(n)) begin
        sel[n] = 1'b1;
      end
    end
    hit = |sel;
  end

endmodule

// File: rtl/dmem_apb_bridge.sv
// Load/store unit to APB3 bridge: stalls the single-cycle core while one transfer
// runs, then presents word-aligned read data and an error pulse in DONE.
module dmem_apb_bridge
  import dmem_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          NUM_SLAVES  = 4,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [31:0]           dAddr,
  input  logic [31:0]           dWdata,
  input  logic [3:0]            wstrb,
  output logic [31:0]           dRdata,
  output logic                  stall,
  output logic                  bus_err,
  output logic [31:0]           PADDR,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  output logic [3:0]            PSTRB,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  bus_state_e        state_q, state_d;
  bus_req_t          req_q, req_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic                  req;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_hit;

  assign req = is_load | is_store;

  apb_addr_decode #(
    .BASE_ADDR  (BASE_ADDR),
    .NUM_SLAVES (NUM_SLAVES)
  ) u_decode (
    .addr (dAddr),
    .sel  (dec_sel),
    .hit  (dec_hit)
  );

  // Select bits above NUM_SLAVES are always zero and never reach PSEL.
  if (NUM_SLAVES < MAX_SLAVES) begin : g_sel_hi
    logic unused_sel_hi;
    assign unused_sel_hi = ^req_q.sel[MAX_SLAVES-1:NUM_SLAVES];
  end

  // State register: every flop of the bridge, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: capture the request, run SETUP/ACCESS, and record the outcome.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          req_d.addr  = {dAddr[31:2], 2'b00};
          req_d.wdata = dWdata;
          req_d.strb  = wstrb;
          req_d.write = is_store;
          req_d.sel   = MAX_SLAVES'(dec_sel);
          cnt_d       = '0;
          if (dec_hit) begin
            err_d   = 1'b0;
            state_d = SETUP;
          end else begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = DONE;
          end
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          if (!req_q.write) begin
            rdata_d = PRDATA;
          end
          err_d   = PSLVERR;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic: APB signals come from the held request so they ignore input churn.
  always_comb begin
    stall   = ((state_q == IDLE) && req) || (state_q == SETUP) || (state_q == ACCESS);
    PSEL    = ((state_q == SETUP) || (state_q == ACCESS)) ? req_q.sel[NUM_SLAVES-1:0] : '0;
    PENABLE = (state_q == ACCESS);
    PADDR   = req_q.addr;
    PWRITE  = req_q.write;
    PWDATA  = req_q.wdata;
    PSTRB   = req_q.strb;
    dRdata  = rdata_q;
    bus_err = (state_q == DONE) && err_q;
  end

endmodule

// File: tb/tb_dmem_apb_bridge.sv
// Directed testbench for dmem_apb_bridge: per-cycle vector table plus
// hand-written sequences for wait states, decode miss, timeout, reset and back-to-back.
module tb_dmem_apb_bridge;

  logic        clk;
  logic        reset;
  logic        is_load;
  logic        is_store;
  logic [31:0] dAddr;
  logic [31:0] dWdata;
  logic [3:0]  wstrb;
  logic [31:0] dRdata;
  logic        stall;
  logic        bus_err;
  logic [31:0] PADDR;
  logic [3:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  int checkCount;
  int errorCount;

  dmem_apb_bridge #(
    .BASE_ADDR   (32'h1000_0000),
    .NUM_SLAVES  (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .is_load  (is_load),
    .is_store (is_store),
    .dAddr    (dAddr),
    .dWdata   (dWdata),
    .wstrb    (wstrb),
    .dRdata   (dRdata),
    .stall    (stall),
    .bus_err  (bus_err),
    .PADDR    (PADDR),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR)
  );

  // Free-running core clock, active edge is posedge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic        ld;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] prdata;
    logic        rdy;
    logic        slverr;
    logic        chkBus;
    logic        eStall;
    logic [3:0]  ePsel;
    logic        ePen;
    logic [31:0] ePaddr;
    logic        ePwrite;
    logic [31:0] ePwdata;
    logic [3:0]  ePstrb;
    logic [31:0] eRdata;
    logic        eErr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(
    input logic ld, input logic st, input logic [31:0] addr, input logic [31:0] wdata,
    input logic [3:0] strb, input logic [31:0] prdata, input logic rdy, input logic slverr,
    input logic chkBus, input logic eStall, input logic [3:0] ePsel, input logic ePen,
    input logic [31:0] ePaddr, input logic ePwrite, input logic [31:0] ePwdata,
    input logic [3:0] ePstrb, input logic [31:0] eRdata, input logic eErr);
    vec_t v;
    v.ld = ld; v.st = st; v.addr = addr; v.wdata = wdata; v.strb = strb;
    v.prdata = prdata; v.rdy = rdy; v.slverr = slverr; v.chkBus = chkBus;
    v.eStall = eStall; v.ePsel = ePsel; v.ePen = ePen; v.ePaddr = ePaddr;
    v.ePwrite = ePwrite; v.ePwdata = ePwdata; v.ePstrb = ePstrb;
    v.eRdata = eRdata; v.eErr = eErr;
    return v;
  endfunction

  // Wait for the inactive edge, drive one cycle's inputs, let comb outputs settle.
  task automatic applyStimulus(
    input logic ld, input logic st, input logic [31:0] addr, input logic [31:0] wdata,
    input logic [3:0] strb, input logic [31:0] prdata, input logic rdy, input logic slverr);
    @(negedge clk);
    is_load  = ld;
    is_store = st;
    dAddr    = addr;
    dWdata   = wdata;
    wstrb    = strb;
    PRDATA   = prdata;
    PREADY   = rdy;
    PSLVERR  = slverr;
    #2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    int accCycles;
    int stallCycles;
    int setups;
    logic doneSeen;
    logic [7:0] b2bStall;
    logic [31:0] a;
    logic [31:0] p;

    checkCount = 0;
    errorCount = 0;
    reset    = 1'b1;
    is_load  = 1'b0;
    is_store = 1'b0;
    dAddr    = '0;
    dWdata   = '0;
    wstrb    = '0;
    PRDATA   = '0;
    PREADY   = 1'b0;
    PSLVERR  = 1'b0;

    // Per-cycle vectors: load slave 0, store byte slave 2, slave error, load+store flags.
    vecs.push_back(mkVec(1,0,32'h1000_0008,0,4'h0,0,0,0, 0, 1,4'b0000,0,0,0,0,4'h0, 32'h0,0));
    vecs.push_back(mkVec(1,0,32'h1000_0008,0,4'h0,0,0,0, 1, 1,4'b0001,0,32'h1000_0008,0,0,4'h0, 32'h0,0));
    vecs.push_back(mkVec(1,0,32'h1000_0008,0,4'h0,32'hDEAD_BEEF,1,0, 1, 1,4'b0001,1,32'h1000_0008,0,0,4'h0, 32'h0,0));
    vecs.push_back(mkVec(1,0,32'h1000_0008,0,4'h0,0,0,0, 0, 0,4'b0000,0,0,0,0,4'h0, 32'hDEAD_BEEF,0));
    vecs.push_back(mkVec(0,1,32'h1000_2003,32'hAB,4'b1000,0,0,0, 0, 1,4'b0000,0,0,0,0,4'h0, 32'hDEAD_BEEF,0));
    vecs.push_back(mkVec(0,1,32'h1000_2003,32'hAB,4'b1000,0,0,0, 1, 1,4'b0100,0,32'h1000_2000,1,32'hAB,4'b1000, 32'hDEAD_BEEF,0));
    vecs.push_back(mkVec(0,1,32'h1000_2003,32'hAB,4'b1000,32'h1234_5678,1,0, 1, 1,4'b0100,1,32'h1000_2000,1,32'hAB,4'b1000, 32'hDEAD_BEEF,0));
    vecs.push_back(mkVec(0,1,32'h1000_2003,32'hAB,4'b1000,0,0,0, 0, 0,4'b0000,0,0,0,0,4'h0, 32'hDEAD_BEEF,0));
    vecs.push_back(mkVec(0,0,32'h0,0,4'h0,0,0,0, 0, 0,4'b0000,0,0,0,0,4'h0, 32'hDEAD_BEEF,0));
    vecs.push_back(mkVec(1,0,32'h1000_3010,0,4'h0,0,0,0, 0, 1,4'b0000,0,0,0,0,4'h0, 32'hDEAD_BEEF,0));
    vecs.push_back(mkVec(1,0,32'h1000_3010,0,4'h0,0,0,0, 1, 1,4'b1000,0,32'h1000_3010,0,0,4'h0, 32'hDEAD_BEEF,0));
    vecs.push_back(mkVec(1,0,32'h1000_3010,0,4'h0,32'hCAFE_F00D,1,1, 1, 1,4'b1000,1,32'h1000_3010,0,0,4'h0, 32'hDEAD_BEEF,0));
    vecs.push_back(mkVec(1,0,32'h1000_3010,0,4'h0,0,0,0, 0, 0,4'b0000,0,0,0,0,4'h0, 32'hCAFE_F00D,1));
    vecs.push_back(mkVec(0,0,32'h0,0,4'h0,0,0,0, 0, 0,4'b0000,0,0,0,0,4'h0, 32'hCAFE_F00D,0));
    vecs.push_back(mkVec(1,1,32'h1000_1004,32'h55AA_55AA,4'b1111,0,0,0, 0, 1,4'b0000,0,0,0,0,4'h0, 32'hCAFE_F00D,0));
    vecs.push_back(mkVec(1,1,32'h1000_1004,32'h55AA_55AA,4'b1111,0,0,0, 1, 1,4'b0010,0,32'h1000_1004,1,32'h55AA_55AA,4'b1111, 32'hCAFE_F00D,0));
    vecs.push_back(mkVec(1,1,32'h1000_1004,32'h55AA_55AA,4'b1111,32'h9999_9999,1,0, 1, 1,4'b0010,1,32'h1000_1004,1,32'h55AA_55AA,4'b1111, 32'hCAFE_F00D,0));
    vecs.push_back(mkVec(1,1,32'h1000_1004,32'h55AA_55AA,4'b1111,0,0,0, 0, 0,4'b0000,0,0,0,0,4'h0, 32'hCAFE_F00D,0));

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #2;
    checkOutput("reset stall",   32'(stall),   32'h0);
    checkOutput("reset PSEL",    32'(PSEL),    32'h0);
    checkOutput("reset PENABLE", 32'(PENABLE), 32'h0);
    checkOutput("reset PADDR",   PADDR,        32'h0);
    checkOutput("reset PWRITE",  32'(PWRITE),  32'h0);
    checkOutput("reset PWDATA",  PWDATA,       32'h0);
    checkOutput("reset PSTRB",   32'(PSTRB),   32'h0);
    checkOutput("reset dRdata",  dRdata,       32'h0);
    checkOutput("reset bus_err", 32'(bus_err), 32'h0);

    // Table-driven cycles.
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].ld, vecs[i].st, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                    vecs[i].prdata, vecs[i].rdy, vecs[i].slverr);
      checkOutput($sformatf("vec%0d stall", i),   32'(stall),   32'(vecs[i].eStall));
      checkOutput($sformatf("vec%0d PSEL", i),    32'(PSEL),    32'(vecs[i].ePsel));
      checkOutput($sformatf("vec%0d PENABLE", i), 32'(PENABLE), 32'(vecs[i].ePen));
      checkOutput($sformatf("vec%0d dRdata", i),  dRdata,       vecs[i].eRdata);
      checkOutput($sformatf("vec%0d bus_err", i), 32'(bus_err), 32'(vecs[i].eErr));
      if (vecs[i].chkBus) begin
        checkOutput($sformatf("vec%0d PADDR", i),  PADDR,       vecs[i].ePaddr);
        checkOutput($sformatf("vec%0d PWRITE", i), 32'(PWRITE), 32'(vecs[i].ePwrite));
        checkOutput($sformatf("vec%0d PWDATA", i), PWDATA,      vecs[i].ePwdata);
        checkOutput($sformatf("vec%0d PSTRB", i),  32'(PSTRB),  32'(vecs[i].ePstrb));
      end
    end

    // Wait states: 5 ACCESS cycles without PREADY, inputs churn after SETUP.
    stallCycles = 0;
    applyStimulus(1, 0, 32'h1000_1008, 32'h0, 4'h0, 32'h0, 0, 0);
    stallCycles += int'(stall);
    applyStimulus(1, 0, 32'h1000_3FFC, 32'hFFFF_FFFF, 4'hF, 32'h0, 0, 0);
    stallCycles += int'(stall);
    checkOutput("ws setup PSEL", 32'(PSEL), 32'b0010);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1, 1, 32'h2000_0000 + 32'(k), 32'hA5A5_0000 + 32'(k), 4'hF,
                    32'h0BAD_F00D, (k == 5), 0);
      stallCycles += int'(stall);
      checkOutput($sformatf("ws%0d PSEL", k),    32'(PSEL),    32'b0010);
      checkOutput($sformatf("ws%0d PENABLE", k), 32'(PENABLE), 32'h1);
      checkOutput($sformatf("ws%0d PADDR", k),   PADDR,        32'h1000_1008);
      checkOutput($sformatf("ws%0d PWRITE", k),  32'(PWRITE),  32'h0);
      checkOutput($sformatf("ws%0d PSTRB", k),   32'(PSTRB),   32'h0);
    end
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0, 0);
    stallCycles += int'(stall);
    checkOutput("ws stall cycles", 32'(stallCycles), 32'd8);
    checkOutput("ws done dRdata",  dRdata,           32'h0BAD_F00D);
    checkOutput("ws done bus_err", 32'(bus_err),     32'h0);

    // Decode miss: IDLE straight to DONE with an error and cleared read data.
    applyStimulus(1, 0, 32'h2000_0000, 32'h0, 4'h0, 32'h0, 0, 0);
    checkOutput("miss idle stall", 32'(stall), 32'h1);
    checkOutput("miss idle PSEL",  32'(PSEL),  32'h0);
    applyStimulus(1, 0, 32'h2000_0000, 32'h0, 4'h0, 32'h0, 0, 0);
    checkOutput("miss done stall",   32'(stall),   32'h0);
    checkOutput("miss done PSEL",    32'(PSEL),    32'h0);
    checkOutput("miss done PENABLE", 32'(PENABLE), 32'h0);
    checkOutput("miss done bus_err", 32'(bus_err), 32'h1);
    checkOutput("miss done dRdata",  dRdata,       32'h0);
    idleCycle();
    checkOutput("miss after bus_err", 32'(bus_err), 32'h0);

    // Set a nonzero dRdata so the timeout clearing it is visible.
    applyStimulus(1, 0, 32'h1000_0000, 32'h0, 4'h0, 32'h0, 0, 0);
    applyStimulus(1, 0, 32'h1000_0000, 32'h0, 4'h0, 32'h0, 0, 0);
    applyStimulus(1, 0, 32'h1000_0000, 32'h0, 4'h0, 32'h7777_7777, 1, 0);
    applyStimulus(0, 0, 32'h0, 32'h0, 4'h0, 32'h0, 0, 0);
    checkOutput("pre-timeout dRdata", dRdata, 32'h7777_7777);

    // Timeout: PREADY never rises; count ACCESS cycles until the core is released.
    accCycles = 0;
    doneSeen  = 1'b0;
    for (int k = 0; k < 40; k++) begin
      applyStimulus(1, 0, 32'h1000_0000, 32'h0, 4'h0, 32'h0, 0, 0);
      if (!stall) begin
        doneSeen = 1'b1;
        break;
      end
      if (PENABLE) accCycles++;
    end
    checkOutput("timeout reached DONE", 32'(doneSeen),  32'h1);
    checkOutput("timeout ACCESS count", 32'(accCycles), 32'd16);
    checkOutput("timeout bus_err",      32'(bus_err),   32'h1);
    checkOutput("timeout dRdata",       dRdata,         32'h0);
    checkOutput("timeout PSEL",         32'(PSEL),      32'h0);

    // Reset in the middle of ACCESS drops the transfer.
    applyStimulus(1, 0, 32'h1000_0004, 32'h0, 4'h0, 32'h0, 0, 0);
    applyStimulus(1, 0, 32'h1000_0004, 32'h0, 4'h0, 32'h0, 0, 0);
    applyStimulus(1, 0, 32'h1000_0004, 32'h0, 4'h0, 32'h0, 0, 0);
    checkOutput("rst pre PENABLE", 32'(PENABLE), 32'h1);
    @(negedge clk);
    reset   = 1'b1;
    is_load = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #2;
    checkOutput("rst stall",   32'(stall),   32'h0);
    checkOutput("rst PSEL",    32'(PSEL),    32'h0);
    checkOutput("rst PENABLE", 32'(PENABLE), 32'h0);
    checkOutput("rst PADDR",   PADDR,        32'h0);

    // Back-to-back loads: two separate SETUP phases with DONE and IDLE between.
    b2bStall = 8'b0111_0111;
    setups   = 0;
    for (int k = 0; k < 8; k++) begin
      a = (k < 4) ? 32'h1000_0010 : 32'h1000_3020;
      p = (k < 4) ? 32'h1111_1111 : 32'h2222_2222;
      applyStimulus(1, 0, a, 32'h0, 4'h0, p, 1, 0);
      checkOutput($sformatf("b2b%0d stall", k), 32'(stall), 32'(b2bStall[k]));
      if ((PSEL != 4'b0000) && !PENABLE) setups++;
      if (k == 5) checkOutput("b2b second PSEL", 32'(PSEL), 32'b1000);
      if (k == 3) checkOutput("b2b first dRdata", dRdata, 32'h1111_1111);
      if (k == 7) checkOutput("b2b second dRdata", dRdata, 32'h2222_2222);
    end
    checkOutput("b2b setup count", 32'(setups), 32'd2);

    idleCycle();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/dmem_apb_bridge.md
Name: dmem_apb_bridge

Overview:
- Sits directly downstream of the CPU datapath's load/store unit.
- Takes the datapath's per-instruction data request (byte address, write data, 4-bit write strobe, load/store flags) and runs it as an APB3-style transfer to one of NUM_SLAVES peripheral/RAM slaves.
- Holds the single-cycle core via a stall output until the transfer completes, then returns word-aligned read data to the load/store unit's read-data input.

Parameters:
- BASE_ADDR, 32'h1000_0000, base of the decoded window.
- NUM_SLAVES, 4, number of PSEL lines; each slave owns 4 KB at BASE_ADDR + n*32'h1000.
- TIMEOUT_CYC, 16, ACCESS cycles allowed before the bridge aborts the transfer with an error.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset (one clock; polarity and synchronicity fixed).
- is_load  in  1  current instruction is a load.
- is_store  in  1  current instruction is a store.
- dAddr  in  32  byte address from the load/store unit.
- dWdata  in  32  store data.
- wstrb  in  4  byte strobes; 0 for loads.
- dRdata  out  32  word-aligned read data to the load/store unit.
- stall  out  1  freeze PC and register-file write enable.
- bus_err  out  1  one-cycle pulse on PSLVERR, decode miss or timeout.
- PADDR  out  32  word-aligned address {dAddr[31:2],2'b00}.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  1 = store.
- PWDATA  out  32  registered dWdata.
- PSTRB  out  4  registered wstrb.
- PRDATA  in  32  slave read data, already muxed by the interconnect.
- PREADY  in  1  slave ready.
- PSLVERR  in  1  slave error.

Behaviour:
- Reset values: state IDLE, all APB outputs 0, dRdata 0, bus_err 0, timeout counter 0.
- Request: req = is_load | is_store, sampled in IDLE. A request with both flags set is treated as a store.
- stall is combinational: 1 when (state==IDLE & req) or state in {SETUP, ACCESS}; 0 in IDLE-without-request and in DONE.
- IDLE -> SETUP on req, registering address, PWRITE, PWDATA, PSTRB and decoded PSEL.
- Decode: slave n is selected when dAddr[31:12] == BASE_ADDR[31:12] + n.
- Decode miss: go IDLE -> DONE directly, no PSEL, dRdata = 0, bus_err pulses in DONE.
- SETUP: PSEL=1, PENABLE=0, one cycle, -> ACCESS.
- ACCESS: PENABLE=1.
  - On PREADY: capture PRDATA (loads only; stores leave dRdata unchanged), capture PSLVERR, -> DONE.
  - Timeout counter increments each ACCESS cycle without PREADY. When it reaches TIMEOUT_CYC-1 without PREADY: abort, dRdata = 0, -> DONE with error.
- DONE: one cycle.
  - PSEL and PENABLE are 0, stall=0, dRdata valid; the core commits writeback and advances PC at this edge.
  - bus_err=1 if an error was recorded.
  - Always -> IDLE, even if req is still high, so the same instruction is never reissued.
- Minimum latency: 3 cycles to DONE (IDLE, SETUP, ACCESS with PREADY=1); the core's instruction occupies 4 clocks including DONE.
- APB outputs stay stable from SETUP through the end of ACCESS, independent of input changes.
- Misaligned requests are already filtered upstream; the bridge does not check alignment and forwards PSTRB as given.
- Reset in any state: next cycle is IDLE, outputs return to reset values, and the in-flight transfer is dropped.

Decomposition:
- Package dmem_bus_pkg:
  - state enum {IDLE, SETUP, ACCESS, DONE}.
  - Defaults for BASE_ADDR and slave window size 32'h1000.
  - Typedef of the registered request struct {addr, wdata, strb, write, sel}.
- One sub-module: apb_addr_decode (combinational address -> one-hot PSEL plus a hit flag), reused later by the instruction-fetch path.

Test Plan:
- Load from slave 0: is_load=1, dAddr=32'h1000_0008, PREADY=1 in the first ACCESS cycle, PRDATA=32'hDEAD_BEEF -> PADDR=32'h1000_0008, PSEL=4'b0001, stall high for 3 cycles, dRdata=32'hDEAD_BEEF in DONE, bus_err=0.
- Store byte to slave 2: is_store=1, dAddr=32'h1000_2003, wstrb=4'b1000, dWdata=32'h0000_00AB -> PADDR=32'h1000_2000, PSTRB=4'b1000, PWRITE=1, PSEL=4'b0100.
- Wait states: PREADY low for 5 ACCESS cycles -> stall stays high for 8 cycles total and all APB outputs stay stable throughout.
- Decode miss: dAddr=32'h2000_0000 -> PSEL never asserts, DONE follows IDLE directly, dRdata=0, bus_err pulses once.
- Timeout and slave error:
  - PREADY held low -> abort after 16 ACCESS cycles with bus_err=1 and dRdata=0.
  - Separately, PSLVERR=1 with PREADY -> bus_err=1 in DONE.
- Reset in ACCESS, then back-to-back requests: reset asserted mid-ACCESS -> next cycle IDLE, PSEL=0, stall=0. Two consecutive loads -> two distinct SETUP phases separated by DONE and IDLE.
